// File: rtl/hybrid_pkg.sv
// Shared definitions for the hybrid stream layer: FSM state encoding,
// output-mode encodings, operand widths and the accumulator width rule.
package hybrid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACC  = 2'd2,
    ST_EMIT = 2'd3
  } state_t;

  localparam int unsigned OUT_MODE_SIGN = 0;
  localparam int unsigned OUT_MODE_RELU = 1;

  localparam int unsigned ACT_W  = 8;
  localparam int unsigned PROD_W = 16;

  // 16-bit products summed over in_width terms can never overflow this width.
  function automatic int unsigned acc_width(input int unsigned in_width);
    return 17 + $clog2(in_width);
  endfunction

endpackage

// File: rtl/mac_tree.sv
// Combinational signed multiply-add: LANES 8x8 signed products (16-bit each)
// reduced by a balanced binary adder tree.
// Ports:
//   act - LANES packed signed 8-bit activations, lane i at [8i+7:8i]
//   wgt - LANES packed signed 8-bit weights, same lane layout
//   sum - signed sum of all lane products, SUM_W bits
module mac_tree
  import hybrid_pkg::*;
#(
  parameter int unsigned LANES = 32,
  parameter int unsigned SUM_W = 25
) (
  input  logic [LANES*ACT_W-1:0] act,
  input  logic [LANES*ACT_W-1:0] wgt,
  output logic signed [SUM_W-1:0] sum
);

  localparam int unsigned DEPTH  = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int unsigned LEAVES = 1 << DEPTH;

  logic signed [PROD_W-1:0] prod [LANES];

  // Lane products; operands are sign-extended before the multiply.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod[i] = PROD_W'($signed(act[i*ACT_W +: ACT_W])) *
                PROD_W'($signed(wgt[i*ACT_W +: ACT_W]));
    end
  end

  // Heap-ordered tree: leaves at [LEAVES, 2*LEAVES-1], root at index 1.
  always_comb begin
    logic signed [SUM_W-1:0] tree [1:2*LEAVES-1];
    for (int i = 0; i < LEAVES; i++) begin
      tree[LEAVES+i] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      tree[LEAVES+i] = SUM_W'(prod[i]);
    end
    for (int i = LEAVES - 1; i >= 1; i--) begin
      tree[i] = tree[2*i] + tree[2*i+1];
    end
    sum = tree[1];
  end

endmodule

// File: rtl/hybrid_stream_layer.sv
// Fully-connected layer over a streamed activation vector. One vector is
// captured per image; each neuron's dot product is accumulated PARALLEL_MACS
// terms per cycle, then reduced to a sign bit (OUT_MODE 0) or a saturated
// 8-bit ReLU value (OUT_MODE 1) against a per-neuron threshold.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   in_valid/in_ready/in_data  - input vector handshake, IN_WIDTH signed bytes
//   wr_en/wr_addr/wr_data      - weight row write (row = neuron*CYC + cycle)
//   thr_we/thr_addr/thr_data   - per-neuron signed threshold write
//   out_valid/out_ready/out_data - result handshake, OUT_WIDTH*OB bits
//   busy                       - high while an image is in flight
module hybrid_stream_layer
  import hybrid_pkg::*;
#(
  parameter  int unsigned IN_WIDTH      = 256,
  parameter  int unsigned OUT_WIDTH     = 128,
  parameter  int unsigned PARALLEL_MACS = 32,
  parameter  int unsigned OUT_MODE      = 0,
  parameter  int unsigned SHIFT         = 8,
  localparam int unsigned CYC   = IN_WIDTH / PARALLEL_MACS,
  localparam int unsigned ACC_W = acc_width(IN_WIDTH),
  localparam int unsigned OB    = (OUT_MODE == OUT_MODE_SIGN) ? 1 : 8,
  localparam int unsigned ROWS  = OUT_WIDTH * CYC,
  localparam int unsigned WA_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned TA_W  = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_WIDTH*ACT_W-1:0]     in_data,
  input  logic                          wr_en,
  input  logic [WA_W-1:0]               wr_addr,
  input  logic [PARALLEL_MACS*ACT_W-1:0] wr_data,
  input  logic                          thr_we,
  input  logic [TA_W-1:0]               thr_addr,
  input  logic [ACC_W-1:0]              thr_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH*OB-1:0]       out_data,
  output logic                          busy
);

  localparam int unsigned CW     = (CYC > 1) ? $clog2(CYC) : 1;
  localparam int unsigned LANE_W = PARALLEL_MACS * ACT_W;
  localparam int unsigned DW     = ACC_W + 1;

  if (IN_WIDTH % PARALLEL_MACS != 0) begin : g_bad_split
    $error("IN_WIDTH must be a multiple of PARALLEL_MACS");
  end
  if (OUT_MODE != OUT_MODE_SIGN && OUT_MODE != OUT_MODE_RELU) begin : g_bad_mode
    $error("OUT_MODE must be 0 or 1");
  end

  state_t                    state;
  logic [IN_WIDTH*ACT_W-1:0] in_buf;
  logic [LANE_W-1:0]         wmem [ROWS];
  logic signed [ACC_W-1:0]   thr [OUT_WIDTH];
  logic signed [ACC_W-1:0]   acc;
  logic [TA_W-1:0]           neuron;
  logic [CW-1:0]             cycle;

  logic [WA_W-1:0]         row_c;
  logic [LANE_W-1:0]       act_c;
  logic [LANE_W-1:0]       wgt_c;
  logic signed [ACC_W-1:0] partial_c;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] thr_c;
  logic [OB-1:0]           result_c;
  logic                    last_cycle_c;
  logic                    last_neuron_c;

  // Operand selection for the current (neuron, cycle) step.
  assign row_c         = WA_W'(32'(neuron) * CYC + 32'(cycle));
  assign act_c         = in_buf[32'(cycle) * LANE_W +: LANE_W];
  assign wgt_c         = wmem[row_c];
  assign thr_c         = thr[neuron];
  assign sum_c         = acc + partial_c;
  assign last_cycle_c  = (cycle == CW'(CYC - 1));
  assign last_neuron_c = (neuron == TA_W'(OUT_WIDTH - 1));

  mac_tree #(
    .LANES (PARALLEL_MACS),
    .SUM_W (ACC_W)
  ) u_mac_tree (
    .act (act_c),
    .wgt (wgt_c),
    .sum (partial_c)
  );

  // Per-neuron output function applied to the completed sum.
  if (OUT_MODE == OUT_MODE_SIGN) begin : g_sign
    assign result_c = OB'(sum_c >= thr_c);
  end else begin : g_relu
    logic signed [DW-1:0] diff_c;
    logic signed [DW-1:0] shr_c;
    // One extra bit so sum - threshold cannot wrap.
    assign diff_c = DW'(sum_c) - DW'(thr_c);
    assign shr_c  = diff_c >>> SHIFT;
    always_comb begin
      result_c = '0;
      if (shr_c[DW-1]) begin
        result_c = '0;
      end else if (shr_c > DW'(127)) begin
        result_c = OB'(127);
      end else begin
        result_c = OB'(shr_c);
      end
    end
  end

  // Weight rows: no reset so the array can live in block RAM.
  always_ff @(posedge clk) begin
    if (wr_en && state == ST_IDLE) begin
      wmem[wr_addr] <= wr_data;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      in_buf    <= '0;
      acc       <= '0;
      neuron    <= '0;
      cycle     <= '0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
        thr[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (thr_we) begin
            thr[thr_addr] <= thr_data;
          end
          if (in_valid && in_ready) begin
            in_buf   <= in_data;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          acc    <= '0;
          neuron <= '0;
          cycle  <= '0;
          state  <= ST_ACC;
        end
        ST_ACC: begin
          if (last_cycle_c) begin
            out_data[32'(neuron) * OB +: OB] <= result_c;
            acc   <= '0;
            cycle <= '0;
            if (last_neuron_c) begin
              neuron <= '0;
              state  <= ST_EMIT;
            end else begin
              neuron <= neuron + TA_W'(1);
            end
          end else begin
            acc   <= sum_c;
            cycle <= cycle + CW'(1);
          end
        end
        ST_EMIT: begin
          // out_valid rises one cycle after entry, then holds until accepted.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hybrid_stream_layer.sv
// Bench for hybrid_stream_layer: a sign-mode and a ReLU-mode instance share
// all stimulus; results are checked against a dot-product model of the layer.
module tb_hybrid_stream_layer;

  localparam int unsigned IW      = 8;
  localparam int unsigned PM      = 4;
  localparam int unsigned OW      = 4;
  localparam int unsigned CYC     = IW / PM;
  localparam int unsigned ACC_W   = 20;
  localparam int unsigned R_SHIFT = 0;
  localparam int unsigned LAT     = OW * CYC + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_data;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        thr_we;
  logic [1:0]  thr_addr;
  logic [19:0] thr_data;
  logic        out_ready;

  logic        s_in_ready, s_out_valid, s_busy;
  logic [3:0]  s_out_data;
  logic        r_in_ready, r_out_valid, r_busy;
  logic [31:0] r_out_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic        pending = 1'b0;
  logic [3:0]  exp_sign = '0;
  logic [31:0] exp_relu = '0;
  logic [3:0]  cap_sign;
  logic [31:0] cap_relu;

  int mw [OW][IW];
  int mthr [OW];
  int mx [IW];

  always #5 clk = ~clk;

  hybrid_stream_layer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .PARALLEL_MACS(PM), .OUT_MODE(0), .SHIFT(8)
  ) u_sign (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(thr_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .busy(s_busy)
  );

  hybrid_stream_layer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .PARALLEL_MACS(PM), .OUT_MODE(1), .SHIFT(R_SHIFT)
  ) u_relu (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r_in_ready),
    .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(thr_data),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
    .busy(r_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic int msum(input int n);
    int s = 0;
    for (int j = 0; j < IW; j++) s += mx[j] * mw[n][j];
    return s;
  endfunction

  function automatic logic [3:0] model_sign();
    logic [3:0] r = '0;
    for (int n = 0; n < OW; n++) r[n] = (msum(n) >= mthr[n]);
    return r;
  endfunction

  function automatic logic [31:0] model_relu();
    logic [31:0] r = '0;
    int d;
    for (int n = 0; n < OW; n++) begin
      d = (msum(n) - mthr[n]) >>> R_SHIFT;
      if (d < 0) d = 0;
      if (d > 127) d = 127;
      r[n*8 +: 8] = 8'(d);
    end
    return r;
  endfunction

  function automatic int rand_byte(input int kind);
    case (kind)
      0:       return int'($urandom_range(0, 255)) - 128;
      1:       return int'($urandom_range(0, 6)) - 3;
      default: return ($urandom_range(0, 1) == 1) ? 127 : -128;
    endcase
  endfunction

  task automatic rand_weights();
    int kind = int'($urandom_range(0, 2));
    for (int n = 0; n < OW; n++)
      for (int j = 0; j < IW; j++) mw[n][j] = rand_byte(kind);
  endtask

  task automatic rand_inputs();
    int kind = int'($urandom_range(0, 2));
    for (int j = 0; j < IW; j++) mx[j] = rand_byte(kind);
  endtask

  // Thresholds are either near the actual sum (exercises the boundary) or wide.
  task automatic rand_thr();
    for (int n = 0; n < OW; n++) begin
      if ($urandom_range(0, 1) == 1) mthr[n] = msum(n) + int'($urandom_range(0, 260)) - 130;
      else mthr[n] = int'($urandom_range(0, 262144)) - 131072;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic load_weights();
    for (int n = 0; n < OW; n++) begin
      for (int c = 0; c < CYC; c++) begin
        wr_en   = 1'b1;
        wr_addr = 3'(n * CYC + c);
        for (int i = 0; i < PM; i++) wr_data[i*8 +: 8] = 8'(mw[n][c*PM+i]);
        @(negedge clk);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic load_thr();
    for (int n = 0; n < OW; n++) begin
      thr_we   = 1'b1;
      thr_addr = 2'(n);
      thr_data = 20'(mthr[n]);
      @(negedge clk);
    end
    thr_we = 1'b0;
  endtask

  task automatic drive_junk();
    wr_en    = 1'($urandom_range(0, 1));
    wr_addr  = 3'($urandom_range(0, 7));
    wr_data  = $urandom;
    thr_we   = 1'($urandom_range(0, 1));
    thr_addr = 2'($urandom_range(0, 3));
    thr_data = 20'($urandom);
    in_data  = {$urandom, $urandom};
  endtask

  task automatic clear_junk();
    wr_en  = 1'b0;
    thr_we = 1'b0;
  endtask

  task automatic start_image();
    for (int j = 0; j < IW; j++) in_data[j*8 +: 8] = 8'(mx[j]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_image(input int hold, input bit junk);
    int lat;
    check("in_ready_idle", 64'({s_in_ready, r_in_ready}), 64'(2'b11));
    exp_sign = model_sign();
    exp_relu = model_relu();
    pending  = 1'b1;
    start_image();
    check("busy_run", 64'({s_busy, r_busy, s_in_ready, r_in_ready}), 64'(4'b1100));
    lat = 0;
    while (!s_out_valid && lat < int'(4 * LAT)) begin
      if (junk) drive_junk();
      @(negedge clk);
      lat++;
    end
    clear_junk();
    check("latency", 64'(lat), 64'(LAT));
    cap_sign = s_out_data;
    cap_relu = r_out_data;
    for (int h = 0; h < hold; h++) begin
      if (junk) drive_junk();
      @(negedge clk);
      check("in_ready_hold", 64'({s_in_ready, r_in_ready}), 64'(0));
    end
    clear_junk();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    pending   = 1'b0;
    check("valid_drop", 64'({s_out_valid, r_out_valid}), 64'(0));
    check("in_ready_after", 64'({s_in_ready, r_in_ready}), 64'(2'b11));
    check("busy_after", 64'({s_busy, r_busy}), 64'(0));
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset && (s_out_valid || r_out_valid)) begin
      check("valid_pair", 64'(r_out_valid), 64'(s_out_valid));
      check("valid_expected", 64'(pending), 64'(1));
      check("sign_data", 64'(s_out_data), 64'(exp_sign));
      check("relu_data", 64'(r_out_data), 64'(exp_relu));
      check("in_ready_emit", 64'({s_in_ready, r_in_ready}), 64'(0));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int vcount;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    thr_we = 1'b0; thr_addr = '0; thr_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_in_ready", 64'({s_in_ready, r_in_ready}), 64'(2'b11));
    check("rst_out_valid", 64'({s_out_valid, r_out_valid}), 64'(0));
    check("rst_busy", 64'({s_busy, r_busy}), 64'(0));
    check("rst_out_data", 64'({s_out_data, r_out_data}), 64'(0));

    // All ones: every neuron sums to 8.
    for (int n = 0; n < OW; n++) begin
      mthr[n] = 0;
      for (int j = 0; j < IW; j++) mw[n][j] = 1;
    end
    for (int j = 0; j < IW; j++) mx[j] = 1;
    load_weights(); load_thr();
    run_image(0, 1'b0);
    check("ones_sign", 64'(cap_sign), 64'(4'b1111));
    check("ones_relu", 64'(cap_relu), 64'(32'h0808_0808));

    // Sum -1016 against thresholds around it.
    for (int n = 0; n < OW; n++)
      for (int j = 0; j < IW; j++) mw[n][j] = -1;
    for (int j = 0; j < IW; j++) mx[j] = 127;
    mthr[0] = 0; mthr[1] = -1016; mthr[2] = -1017; mthr[3] = -1015;
    load_weights(); load_thr();
    run_image(0, 1'b0);
    check("edge_sign", 64'(cap_sign), 64'(4'b0110));
    check("edge_relu", 64'(cap_relu), 64'(32'h0001_0000));

    // Extreme operands: +131072 and -130048.
    for (int n = 0; n < OW; n++) begin
      mthr[n] = 0;
      for (int j = 0; j < IW; j++) mw[n][j] = -128;
    end
    for (int j = 0; j < IW; j++) mx[j] = -128;
    load_weights(); load_thr();
    run_image(0, 1'b0);
    check("max_sign", 64'(cap_sign), 64'(4'b1111));
    check("max_relu", 64'(cap_relu), 64'(32'h7f7f_7f7f));
    for (int n = 0; n < OW; n++)
      for (int j = 0; j < IW; j++) mw[n][j] = 127;
    load_weights();
    run_image(0, 1'b0);
    check("min_sign", 64'(cap_sign), 64'(4'b0000));
    check("min_relu", 64'(cap_relu), 64'(32'h0000_0000));

    // Long back-pressure with writes attempted while busy, then a second image.
    rand_weights(); rand_inputs(); rand_thr();
    load_weights(); load_thr();
    run_image(20, 1'b1);
    rand_inputs();
    run_image(0, 1'b0);

    // Reset during the third ACC cycle aborts the image and clears thresholds.
    rand_inputs(); rand_thr();
    load_thr();
    start_image();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < OW; n++) mthr[n] = 0;
    check("abort_valid", 64'({s_out_valid, r_out_valid}), 64'(0));
    check("abort_in_ready", 64'({s_in_ready, r_in_ready}), 64'(2'b11));
    check("abort_busy", 64'({s_busy, r_busy}), 64'(0));
    check("abort_data", 64'({s_out_data, r_out_data}), 64'(0));
    vcount = 0;
    repeat (LAT + 6) begin
      @(negedge clk);
      if (s_out_valid || r_out_valid) vcount++;
    end
    check("abort_no_valid", 64'(vcount), 64'(0));
    rand_inputs();
    run_image(0, 1'b0);

    // Randomized images with junk writes and random back-pressure.
    for (int k = 0; k < 30; k++) begin
      rand_inputs();
      if ($urandom_range(0, 2) != 0) begin
        rand_weights();
        load_weights();
      end
      rand_thr();
      load_thr();
      run_image(int'($urandom_range(0, 3)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
